// File: rtl/pwm_detect_pkg.sv
// Shared types and helpers for the PWM pulse-width detector.
package pwm_detect_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_HIGH, ST_LOW} state_e;

    localparam int DEF_CNT_W   = 32;
    localparam int DEF_TIMEOUT = 1_000_000;

    // Sum of two w-bit values (w <= 64), clamped to w ones instead of wrapping.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [63:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (sum > {1'b0, lim}) ? lim : sum[63:0];
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizes the asynchronous PWM input and derives single-cycle edge pulses.
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sysclk,
    input  logic sysreset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;

    always_ff @(posedge sysclk) begin
        if (!sysreset_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            s_d_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~s_d_q;
    assign fall  = ~level & s_d_q;

endmodule

// File: rtl/pwm_detect.sv
// Measures high time and rise-to-rise period of a PWM input in sysclk cycles,
// with a quiet-line timeout that flags a stuck-high or stuck-low input.
module pwm_detect
    import pwm_detect_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             sysclk,
    input  logic             sysreset_n,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] period_count,
    output logic             duty_valid,
    output logic             stuck_high,
    output logic             stuck_low
);

    localparam logic [CNT_W-1:0] QUIET_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic s, rise, fall;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [CNT_W-1:0] quiet_q, quiet_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             dv_q, dv_d;
    logic             sh_q, sh_d;
    logic             sl_q, sl_d;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .sysclk    (sysclk),
        .sysreset_n(sysreset_n),
        .async_in  (pwm_in),
        .level     (s),
        .rise      (rise),
        .fall      (fall)
    );

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_add(64'(v), 64'd1, CNT_W));
    endfunction

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        lcnt_d  = lcnt_q;
        quiet_d = quiet_q;
        high_d  = high_q;
        per_d   = per_q;
        dv_d    = 1'b0;
        sh_d    = sh_q;
        sl_d    = sl_q;

        if (!enable) begin
            // Published results and stuck flags survive a disable.
            state_d = ST_IDLE;
            hcnt_d  = '0;
            lcnt_d  = '0;
            quiet_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    hcnt_d  = '0;
                    lcnt_d  = '0;
                    quiet_d = '0;
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        hcnt_d  = ONE;
                        lcnt_d  = '0;
                        state_d = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        lcnt_d  = ONE;
                        state_d = ST_LOW;
                    end else begin
                        hcnt_d = inc(hcnt_q);
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        high_d  = hcnt_q;
                        per_d   = CNT_W'(sat_add(64'(hcnt_q), 64'(lcnt_q), CNT_W));
                        dv_d    = 1'b1;
                        sh_d    = 1'b0;
                        sl_d    = 1'b0;
                        hcnt_d  = ONE;
                        lcnt_d  = '0;
                        state_d = ST_HIGH;
                    end else begin
                        lcnt_d = inc(lcnt_q);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // An edge in the same cycle as the timeout takes priority.
            if (state_q != ST_IDLE) begin
                if (rise || fall) begin
                    quiet_d = '0;
                end else if (quiet_q >= QUIET_MAX) begin
                    sh_d    = s;
                    sl_d    = ~s;
                    quiet_d = '0;
                    state_d = ST_ARM;
                end else begin
                    quiet_d = inc(quiet_q);
                end
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (!sysreset_n) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            lcnt_q  <= '0;
            quiet_q <= '0;
            high_q  <= '0;
            per_q   <= '0;
            dv_q    <= 1'b0;
            sh_q    <= 1'b0;
            sl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            lcnt_q  <= lcnt_d;
            quiet_q <= quiet_d;
            high_q  <= high_d;
            per_q   <= per_d;
            dv_q    <= dv_d;
            sh_q    <= sh_d;
            sl_q    <= sl_d;
        end
    end

    assign high_count   = high_q;
    assign period_count = per_q;
    assign duty_valid   = dv_q;
    assign stuck_high   = sh_q;
    assign stuck_low    = sl_q;

endmodule

// File: tb/tb_pwm_detect.sv
// Self-checking bench: PWM segments are driven while a segment-level model
// predicts every published (high, period) pair and its strobe timing.
module tb_pwm_detect;

    localparam int SYNC = 2;
    localparam int TO   = 1000;
    localparam int TO8  = 250;

    logic        sysclk = 1'b0;
    logic        sysreset_n, enable, pwm_in;
    logic [31:0] high_count, period_count;
    logic        duty_valid, stuck_high, stuck_low;
    logic [7:0]  high8, per8;
    logic        dv8, sh8, sl8;

    always #5 sysclk = ~sysclk;

    pwm_detect #(.CNT_W(32), .SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
        .sysclk      (sysclk),
        .sysreset_n  (sysreset_n),
        .enable      (enable),
        .pwm_in      (pwm_in),
        .high_count  (high_count),
        .period_count(period_count),
        .duty_valid  (duty_valid),
        .stuck_high  (stuck_high),
        .stuck_low   (stuck_low)
    );

    pwm_detect #(.CNT_W(8), .SYNC_STAGES(SYNC), .TIMEOUT(TO8)) dut8 (
        .sysclk      (sysclk),
        .sysreset_n  (sysreset_n),
        .enable      (enable),
        .pwm_in      (pwm_in),
        .high_count  (high8),
        .period_count(per8),
        .duty_valid  (dv8),
        .stuck_high  (sh8),
        .stuck_low   (sl8)
    );

    typedef struct {
        longint h;
        longint p;
        int     cyc;
    } rec_t;

    rec_t   cap[$];
    rec_t   cap8[$];
    rec_t   expq[$];
    int     cyc  = 0;
    int     nvec = 0;
    int     nbad = 0;

    bit     m_lvl = 1'b0;
    bit     m_arm = 1'b0;
    longint m_h   = 0;
    longint m_l   = 0;

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(posedge sysclk) begin : mon
        rec_t r;
        #1;
        if (duty_valid) begin
            r.h = longint'(high_count); r.p = longint'(period_count); r.cyc = cyc;
            cap.push_back(r);
        end
        if (dv8) begin
            r.h = longint'(high8); r.p = longint'(per8); r.cyc = cyc;
            cap8.push_back(r);
        end
    end

    task automatic chk(input string tag, input longint got, input longint want);
        nvec++;
        if (got != want) begin
            nbad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    // Hold pwm_in at lvl for n cycles. Each rise after an armed rise closes a
    // period whose high/low lengths are simply the segment lengths seen since.
    task automatic seg(input bit lvl, input int n);
        rec_t r;
        if (lvl && !m_lvl) begin
            if (m_arm) begin
                r.h = m_h; r.p = m_h + m_l; r.cyc = cyc;
                expq.push_back(r);
            end
            m_arm = 1'b1;
            m_h   = 0;
            m_l   = 0;
        end
        if (lvl) m_h += n; else m_l += n;
        m_lvl  = lvl;
        pwm_in = lvl;
        run(n);
    endtask

    task automatic start_phase();
        cap.delete();
        cap8.delete();
        expq.delete();
    endtask

    task automatic cmp_phase(input string tag, input bit use8);
        int     n, d;
        rec_t   c;
        longint mx, wh, wp;
        mx = use8 ? 64'd255 : 64'hFFFF_FFFF;
        n  = use8 ? cap8.size() : cap.size();
        chk({tag, ".n"}, longint'(n), longint'(expq.size()));
        for (int i = 0; i < n && i < expq.size(); i++) begin
            if (use8) c = cap8[i]; else c = cap[i];
            wh = (expq[i].h > mx) ? mx : expq[i].h;
            wp = (expq[i].p > mx) ? mx : expq[i].p;
            d  = c.cyc - expq[i].cyc;
            chk({tag, ".h"}, c.h, wh);
            chk({tag, ".p"}, c.p, wp);
            chk({tag, ".lat"}, longint'((d >= SYNC + 1) && (d <= SYNC + 2)), 64'd1);
        end
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: got no finish want finish within 60000 cycles");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        sysreset_n = 1'b0;
        enable     = 1'b0;
        pwm_in     = 1'b0;
        run(3);
        chk("rst.hc", longint'(high_count), 64'd0);
        chk("rst.pc", longint'(period_count), 64'd0);
        chk("rst.dv", longint'(duty_valid), 64'd0);
        chk("rst.sh", longint'(stuck_high), 64'd0);
        chk("rst.sl", longint'(stuck_low), 64'd0);
        sysreset_n = 1'b1;
        run(2);

        // 30 high / 70 low, five times: four complete periods published
        start_phase();
        enable = 1'b1;
        seg(1'b0, 10);
        repeat (5) begin
            seg(1'b1, 30);
            seg(1'b0, 70);
        end
        cmp_phase("p30", 1'b0);
        chk("p30.hc", longint'(high_count), 64'd30);
        chk("p30.pc", longint'(period_count), 64'd100);

        // held high past the timeout, then a 10/10 waveform
        start_phase();
        seg(1'b1, TO + 1);
        chk("sth.early", longint'(stuck_high), 64'd0);
        seg(1'b1, 3);
        chk("sth.sh", longint'(stuck_high), 64'd1);
        chk("sth.sl", longint'(stuck_low), 64'd0);
        chk("sth.hc", longint'(high_count), 64'd30);
        chk("sth.pc", longint'(period_count), 64'd100);
        m_arm = 1'b0;
        seg(1'b0, 10);
        repeat (4) begin
            seg(1'b1, 10);
            seg(1'b0, 10);
        end
        cmp_phase("sth", 1'b0);
        chk("sth.clr", longint'(stuck_high), 64'd0);
        chk("sth.hc2", longint'(high_count), 64'd10);
        chk("sth.pc2", longint'(period_count), 64'd20);

        // held low past the timeout
        start_phase();
        seg(1'b0, TO + 4);
        chk("stl.sl", longint'(stuck_low), 64'd1);
        chk("stl.sh", longint'(stuck_high), 64'd0);
        chk("stl.hc", longint'(high_count), 64'd10);
        m_arm = 1'b0;
        cmp_phase("stl", 1'b0);

        // single-cycle high pulses every 5 cycles
        start_phase();
        repeat (6) begin
            seg(1'b1, 1);
            seg(1'b0, 4);
        end
        seg(1'b0, 6);
        cmp_phase("pls", 1'b0);
        chk("pls.sl", longint'(stuck_low), 64'd0);

        // random high/low lengths
        start_phase();
        repeat (25) begin
            seg(1'b1, int'($urandom_range(40, 1)));
            seg(1'b0, int'($urandom_range(40, 1)));
        end
        seg(1'b1, 2);
        seg(1'b0, 8);
        cmp_phase("rnd", 1'b0);

        // enable dropped mid-high for three cycles
        start_phase();
        seg(1'b1, 20);
        seg(1'b0, 20);
        seg(1'b1, 8);
        enable = 1'b0;
        m_arm  = 1'b0;
        seg(1'b1, 3);
        chk("en.hold", longint'(high_count), 64'd20);
        enable = 1'b1;
        seg(1'b1, 19);
        seg(1'b0, 25);
        seg(1'b1, 20);
        seg(1'b0, 20);
        seg(1'b1, 20);
        seg(1'b0, 20);
        seg(1'b1, 5);
        seg(1'b0, 8);
        cmp_phase("en", 1'b0);

        // one-cycle reset in the middle of a low phase
        start_phase();
        seg(1'b1, 30);
        seg(1'b0, 70);
        seg(1'b1, 30);
        seg(1'b0, 20);
        chk("rs.pre", longint'(high_count), 64'd30);
        sysreset_n = 1'b0;
        run(1);
        sysreset_n = 1'b1;
        chk("rs.hc", longint'(high_count), 64'd0);
        chk("rs.pc", longint'(period_count), 64'd0);
        chk("rs.dv", longint'(duty_valid), 64'd0);
        chk("rs.sh", longint'(stuck_high), 64'd0);
        chk("rs.sl", longint'(stuck_low), 64'd0);
        cmp_phase("rs.a", 1'b0);
        start_phase();
        m_arm = 1'b0;
        seg(1'b0, 50);
        repeat (2) begin
            seg(1'b1, 30);
            seg(1'b0, 70);
        end
        seg(1'b1, 2);
        seg(1'b0, 6);
        cmp_phase("rs.b", 1'b0);

        // 200/200: 400 fits 32 bits, saturates at 255 in the 8-bit instance
        start_phase();
        repeat (2) begin
            seg(1'b1, 200);
            seg(1'b0, 200);
        end
        seg(1'b1, 5);
        seg(1'b0, 8);
        cmp_phase("sat32", 1'b0);
        cmp_phase("sat8", 1'b1);
        chk("sat8.hc", longint'(high8), 64'd200);
        chk("sat8.pc", longint'(per8), 64'd255);
        chk("sat32.pc", longint'(period_count), 64'd400);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/pwm_detect.md
# pwm_detect

Hardware pulse-width detector for the PWM feedback path on the Nexys 4 top level. It samples an asynchronous PWM waveform returned on the PmodENC/feedback header and measures two things in `sysclk` cycles: the high time and the full period (rising edge to rising edge). Each completed period is published with a one-cycle valid strobe. A constant-level input is flagged after a timeout. The block receives the signal that the embedded system's axi_timer PWM output generates, and its results are read by the embedded system.

## Interface
Parameters:
- `CNT_W`, 32, width of all counters and measurement outputs.
- `SYNC_STAGES`, 2, synchronizer flop count on `pwm_in`; legal values 2..4.
- `TIMEOUT`, 1_000_000, cycles without any edge before a stuck flag is set; must be < 2^CNT_W.

Ports:
- `sysclk`  in  1  system clock, 100 MHz.
- `sysreset_n`  in  1  reset, synchronous, active-low; one clock; reset is synchronous and active-low.
- `enable`  in  1  synchronous; measuring runs only while high.
- `pwm_in`  in  1  asynchronous PWM input.
- `high_count`  out  CNT_W  high time of the last completed period, in cycles.
- `period_count`  out  CNT_W  length of the last completed period, in cycles.
- `duty_valid`  out  1  one-cycle strobe; asserted when the two counts above update.
- `stuck_high`  out  1  sticky; input held high for TIMEOUT cycles.
- `stuck_low`  out  1  sticky; input held low for TIMEOUT cycles.

## Operation
- `pwm_in` passes through SYNC_STAGES flops to give `s`, and `s` is delayed one cycle to give `s_d`.
- `rise` = s & ~s_d; `fall` = ~s & s_d.
- Internal counters: `hcnt`, `lcnt` and `quiet`, all CNT_W bits and all saturating at all-ones.
- States:
  - IDLE: counters held at 0. When `enable` is high, go to ARM.
  - ARM: wait for `rise`. On `rise`: hcnt=1, lcnt=0, go to HIGH. A fall in ARM is ignored.
  - HIGH: on `fall`, lcnt=1 and go to LOW; otherwise hcnt++.
  - LOW: on `rise`, do the following and go to HIGH; otherwise lcnt++.
    - high_count=hcnt.
    - period_count=sat(hcnt+lcnt), computed at CNT_W+1 bits and clamped to all-ones.
    - duty_valid=1; clear both stuck flags.
    - hcnt=1, lcnt=0.
- `quiet` (all states except IDLE):
  - Cleared on any edge; otherwise incremented.
  - When quiet reaches TIMEOUT-1 without an edge: set stuck_high=s and stuck_low=~s, clear quiet, go to ARM.
  - The published counts are not changed.
- `enable` low in any state: go to IDLE on the next cycle and clear hcnt/lcnt/quiet. Outputs and stuck flags hold their values.
- The first `duty_valid` after leaving IDLE or ARM requires two rising edges. Partial periods are never published.
- A 1-cycle high pulse (after synchronization) is legal and gives high_count=1.
- Input pulses shorter than one `sysclk` period may be lost. This is acceptable.

## Timing
- Reset: every output is 0, state=IDLE, synchronizer flops are 0, all counters are 0.
- Latency from a `pwm_in` edge to `duty_valid` (or to stuck flag set) is SYNC_STAGES+2 cycles: the sync stages, the `s_d` stage, and the registered output.
- `duty_valid` is high for exactly one cycle per period. It never asserts in back-to-back cycles, because the minimum period is 2.
- Reset asserted mid-measurement: on the next edge all state is lost and outputs return to 0.
- If `rise` and the timeout would occur in the same cycle, the edge wins: quiet clears and no stuck flag is set.

## Structure
- Package `pwm_detect_pkg` holds:
  - the state enum (IDLE, ARM, HIGH, LOW);
  - the default CNT_W and TIMEOUT constants;
  - the saturating-add function.
- Sub-module `pwm_sync_edge`:
  - parameter SYNC_STAGES;
  - ports `sysclk`, `sysreset_n`, `async_in`, `level`, `rise`, `fall`.
- FSM and counters are in the top module.

## Test plan
- Enable, then 30 cycles high / 70 low, repeated 5 times → first strobe at the 2nd rise + 4 cycles; high_count=30, period_count=100; 4 strobes in total.
- `pwm_in` held high with TIMEOUT=1000 → stuck_high=1 by 1000+4 cycles after the last edge; stuck_low=0; counts unchanged. Then a 10/10 waveform → stuck_high clears on the first strobe; high_count=10, period_count=20.
- 1-cycle-high pulses every 5 cycles → high_count=1, period_count=5.
- `enable` dropped mid-HIGH for 3 cycles, then restored → no strobe for the partial period; the next strobe follows two fresh rising edges with correct counts.
- `sysreset_n` low for 1 cycle mid-LOW with high_count=30 published → all outputs 0 on the next cycle; the FSM resumes from IDLE.
- CNT_W=8, TIMEOUT=250, 200 high / 200 low → high_count=200 and period_count=255 (saturated).
